// File: rtl/i2c_cmd_sequencer_pkg.sv
// rtl/i2c_cmd_sequencer_pkg.sv - shared types and width constants for the I2C command sequencer
package i2c_cmd_sequencer_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;
  localparam int I2C_LEN_W  = 4;
  localparam int NUM_REQ    = 2;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } i2c_op_t;

  typedef enum logic [2:0] {
    CMD_START    = 3'd0,
    CMD_STOP     = 3'd1,
    CMD_WRITE    = 3'd2,
    CMD_READ_ACK = 3'd3,
    CMD_READ_NAK = 3'd4
  } i2c_cmd_t;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_NAK      = 2'd1,
    ST_ARB_LOST = 2'd2,
    ST_BAD_LEN  = 2'd3
  } i2c_status_t;

  function automatic logic [NUM_REQ-1:0] owner_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/i2c_rr_arbiter.sv
// rtl/i2c_rr_arbiter.sv - two-way round-robin arbiter whose priority toggles on every grant
module i2c_rr_arbiter
  import i2c_cmd_sequencer_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               ptr_o
);

  always_comb begin
    grant_o = '0;
    if (!ptr_o) begin
      if (req_i[0])      grant_o = 2'b01;
      else if (req_i[1]) grant_o = 2'b10;
    end else begin
      if (req_i[1])      grant_o = 2'b10;
      else if (req_i[0]) grant_o = 2'b01;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_o <= 1'b0;
    end else if (advance_i) begin
      ptr_o <= ~ptr_o;
    end
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// rtl/i2c_cmd_sequencer.sv - arbitrates two requesters and sequences I2C byte-engine commands
module i2c_cmd_sequencer
  import i2c_cmd_sequencer_pkg::*;
#(
  parameter int I2C_ADDR_WIDTH = I2C_ADDR_W,
  parameter int I2C_DATA_WIDTH = I2C_DATA_W,
  parameter int LEN_WIDTH      = I2C_LEN_W
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [1:0]                  req_valid_i,
  output logic [1:0]                  req_ready_o,
  input  logic [2*I2C_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [1:0]                  req_op_i,
  input  logic [2*LEN_WIDTH-1:0]      req_len_i,
  input  logic [2*I2C_DATA_WIDTH-1:0] wdata_i,
  input  logic [1:0]                  wdata_valid_i,
  output logic [1:0]                  wdata_ready_o,
  output logic [I2C_DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]                  rdata_valid_o,
  output logic                        rdata_last_o,
  output logic [1:0]                  done_o,
  output logic [1:0]                  status_o,
  output logic                        cmd_valid_o,
  input  logic                        cmd_ready_i,
  output logic [2:0]                  cmd_o,
  output logic [I2C_DATA_WIDTH-1:0]   cmd_wdata_o,
  input  logic                        rsp_valid_i,
  input  logic                        rsp_nak_i,
  input  logic                        rsp_arb_lost_i,
  input  logic [I2C_DATA_WIDTH-1:0]   rsp_rdata_i
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]                state;
  logic                      pend;
  logic                      owner;
  logic [I2C_ADDR_WIDTH-1:0] addr_q;
  i2c_op_t                   op_q;
  logic [LEN_WIDTH-1:0]      len_q;
  logic [LEN_WIDTH-1:0]      cnt;
  i2c_status_t               status_q;

  logic [1:0]                grant;
  logic                      rr_ptr;
  logic                      advance;
  logic                      win;
  logic [I2C_ADDR_WIDTH-1:0] win_addr;
  logic [LEN_WIDTH-1:0]      win_len;
  logic [I2C_DATA_WIDTH-1:0] owner_wdata;
  logic [1:0]                owner_oh;
  logic [LEN_WIDTH-1:0]      cnt_next;
  logic                      issue_ok;
  logic                      rsp_fire;
  logic                      last_byte;

  i2c_rr_arbiter u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_valid_i),
    .advance_i (advance),
    .grant_o   (grant),
    .ptr_o     (rr_ptr)
  );

  // Winner index follows the priority pointer: the favoured requester wins if it is asking.
  assign win         = rr_ptr ? req_valid_i[1] : ~req_valid_i[0];
  assign advance     = (state == S_IDLE) && (|grant);
  assign win_addr    = win ? req_addr_i[2*I2C_ADDR_WIDTH-1:I2C_ADDR_WIDTH] : req_addr_i[I2C_ADDR_WIDTH-1:0];
  assign win_len     = win ? req_len_i[2*LEN_WIDTH-1:LEN_WIDTH] : req_len_i[LEN_WIDTH-1:0];
  assign owner_wdata = owner ? wdata_i[2*I2C_DATA_WIDTH-1:I2C_DATA_WIDTH] : wdata_i[I2C_DATA_WIDTH-1:0];
  assign owner_oh    = owner_onehot(owner);
  assign cnt_next    = cnt + LEN_WIDTH'(1);
  assign last_byte   = (cnt_next == len_q);

  // A new command may only be raised once the previous one has been answered.
  assign issue_ok = !pend && !cmd_valid_o;
  assign rsp_fire = pend && rsp_valid_i;

  assign wdata_ready_o = (state == S_WDATA && issue_ok) ? owner_oh : 2'b00;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      pend          <= 1'b0;
      owner         <= 1'b0;
      addr_q        <= '0;
      op_q          <= OP_WRITE;
      len_q         <= '0;
      cnt           <= '0;
      status_q      <= ST_OK;
      req_ready_o   <= '0;
      rdata_o       <= '0;
      rdata_valid_o <= '0;
      rdata_last_o  <= 1'b0;
      done_o        <= '0;
      status_o      <= ST_OK;
      cmd_valid_o   <= 1'b0;
      cmd_o         <= '0;
      cmd_wdata_o   <= '0;
    end else begin
      req_ready_o   <= '0;
      rdata_valid_o <= '0;
      rdata_last_o  <= 1'b0;
      done_o        <= '0;

      if (cmd_valid_o && cmd_ready_i) begin
        cmd_valid_o <= 1'b0;
        pend        <= 1'b1;
      end
      if (rsp_fire) begin
        pend <= 1'b0;
      end

      // Losing arbitration ends the transfer on the spot; the bus is no longer ours to STOP.
      if (rsp_fire && rsp_arb_lost_i) begin
        status_q <= ST_ARB_LOST;
        state    <= S_DONE;
      end else begin
        case (state)
          S_IDLE: begin
            if (|grant) begin
              req_ready_o <= grant;
              owner       <= win;
              addr_q      <= win_addr;
              op_q        <= i2c_op_t'(req_op_i[win]);
              len_q       <= win_len;
              cnt         <= '0;
              if (win_len == '0) begin
                status_q <= ST_BAD_LEN;
                state    <= S_DONE;
              end else begin
                status_q <= ST_OK;
                state    <= S_START;
              end
            end
          end
          S_START: begin
            if (issue_ok) begin
              cmd_valid_o <= 1'b1;
              cmd_o       <= CMD_START;
            end else if (rsp_fire) begin
              state <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (issue_ok) begin
              cmd_valid_o <= 1'b1;
              cmd_o       <= CMD_WRITE;
              cmd_wdata_o <= I2C_DATA_WIDTH'({addr_q, op_q});
            end else if (rsp_fire) begin
              if (rsp_nak_i) begin
                status_q <= ST_NAK;
                state    <= S_STOP;
              end else if (op_q == OP_READ) begin
                state <= S_RDATA;
              end else begin
                state <= S_WDATA;
              end
            end
          end
          S_WDATA: begin
            if (issue_ok && wdata_valid_i[owner]) begin
              cmd_valid_o <= 1'b1;
              cmd_o       <= CMD_WRITE;
              cmd_wdata_o <= owner_wdata;
            end else if (rsp_fire) begin
              if (rsp_nak_i) begin
                status_q <= ST_NAK;
                state    <= S_STOP;
              end else begin
                cnt <= cnt_next;
                if (last_byte) state <= S_STOP;
              end
            end
          end
          S_RDATA: begin
            if (issue_ok) begin
              cmd_valid_o <= 1'b1;
              cmd_o       <= last_byte ? CMD_READ_NAK : CMD_READ_ACK;
            end else if (rsp_fire) begin
              rdata_o       <= rsp_rdata_i;
              rdata_valid_o <= owner_oh;
              rdata_last_o  <= last_byte;
              cnt           <= cnt_next;
              if (last_byte) state <= S_STOP;
            end
          end
          S_STOP: begin
            if (issue_ok) begin
              cmd_valid_o <= 1'b1;
              cmd_o       <= CMD_STOP;
            end else if (rsp_fire) begin
              state <= S_DONE;
            end
          end
          S_DONE: begin
            done_o   <= owner_oh;
            status_o <= status_q;
            state    <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb/tb_i2c_cmd_sequencer.sv - scoreboard bench for the I2C command sequencer
module tb_i2c_cmd_sequencer;
  import i2c_cmd_sequencer_pkg::*;

  typedef struct packed {
    logic       nak;
    logic       arb;
    logic [7:0] data;
  } rsp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [13:0] req_addr_i;
  logic [1:0]  req_op_i;
  logic [7:0]  req_len_i;
  logic [15:0] wdata_i;
  logic [1:0]  wdata_valid_i;
  logic [1:0]  wdata_ready_o;
  logic [7:0]  rdata_o;
  logic [1:0]  rdata_valid_o;
  logic        rdata_last_o;
  logic [1:0]  done_o;
  logic [1:0]  status_o;
  logic        cmd_valid_o;
  logic        cmd_ready_i;
  logic [2:0]  cmd_o;
  logic [7:0]  cmd_wdata_o;
  logic        rsp_valid_i;
  logic        rsp_nak_i;
  logic        rsp_arb_lost_i;
  logic [7:0]  rsp_rdata_i;

  always #5 clk_i = ~clk_i;

  i2c_cmd_sequencer dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .req_op_i       (req_op_i),
    .req_len_i      (req_len_i),
    .wdata_i        (wdata_i),
    .wdata_valid_i  (wdata_valid_i),
    .wdata_ready_o  (wdata_ready_o),
    .rdata_o        (rdata_o),
    .rdata_valid_o  (rdata_valid_o),
    .rdata_last_o   (rdata_last_o),
    .done_o         (done_o),
    .status_o       (status_o),
    .cmd_valid_o    (cmd_valid_o),
    .cmd_ready_i    (cmd_ready_i),
    .cmd_o          (cmd_o),
    .cmd_wdata_o    (cmd_wdata_o),
    .rsp_valid_i    (rsp_valid_i),
    .rsp_nak_i      (rsp_nak_i),
    .rsp_arb_lost_i (rsp_arb_lost_i),
    .rsp_rdata_i    (rsp_rdata_i)
  );

  logic [10:0] cmd_q[$];
  logic [10:0] rd_q[$];
  logic [3:0]  done_q[$];
  logic [1:0]  grant_q[$];
  rsp_t        rsp_q[$];
  logic [7:0]  wq0[$];
  logic [7:0]  wq1[$];

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int rd_seen = 0;
  int cmd_seen = 0;
  int wready_cycles = 0;
  bit busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected no event", name, act);
  endtask

  task automatic exp_cmd(input i2c_cmd_t c, input logic [7:0] d);
    cmd_q.push_back({c, d});
  endtask

  task automatic exp_rsp(input logic nak, input logic arb, input logic [7:0] d);
    rsp_q.push_back('{nak: nak, arb: arb, data: d});
  endtask

  task automatic acks(input int n);
    for (int i = 0; i < n; i++) exp_rsp(1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strobes"}, {req_ready_o, wdata_ready_o, rdata_valid_o, done_o, cmd_valid_o, rdata_last_o}, 0);
    check({tag, "_status"}, status_o, ST_OK);
    check({tag, "_rdata"}, rdata_o, 0);
    check({tag, "_cmd"}, cmd_o, 0);
    check({tag, "_cmd_wdata"}, cmd_wdata_o, 0);
  endtask

  task automatic issue(input int r, input logic [6:0] a, input logic op, input logic [3:0] len);
    bit got;
    got = 1'b0;
    req_addr_i[r*7 +: 7] = a;
    req_op_i[r] = op;
    req_len_i[r*4 +: 4] = len;
    req_valid_i[r] = 1'b1;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk_i);
      if (req_ready_o[r]) got = 1'b1;
    end
    req_valid_i[r] = 1'b0;
    if (!got) unexpected("grant_timeout", r);
  endtask

  task automatic wait_done(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk_i);
      if (done_seen >= target) ok = 1'b1;
    end
    if (!ok) check("done_timeout", done_seen, target);
  endtask

  // Byte engine: random ready, answers each accepted command two cycles later.
  initial begin
    bit   hs;
    int   dly;
    rsp_t cur;
    dly = 0;
    cur = '0;
    cmd_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    rsp_nak_i = 1'b0;
    rsp_arb_lost_i = 1'b0;
    rsp_rdata_i = 8'h00;
    forever begin
      @(negedge clk_i);
      hs = cmd_valid_o && cmd_ready_i && !rst_i;
      @(posedge clk_i);
      #1;
      rsp_valid_i = 1'b0;
      rsp_nak_i = 1'b0;
      rsp_arb_lost_i = 1'b0;
      rsp_rdata_i = 8'h00;
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          rsp_valid_i = 1'b1;
          rsp_nak_i = cur.nak;
          rsp_arb_lost_i = cur.arb;
          rsp_rdata_i = cur.data;
        end
      end
      if (hs) begin
        check("one_outstanding", dly, 0);
        cur = (rsp_q.size() > 0) ? rsp_q.pop_front() : '0;
        dly = 2;
      end
      cmd_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // Write-data sources, one byte queue per requester.
  initial begin
    logic [1:0] take;
    wdata_valid_i = 2'b00;
    wdata_i = 16'h0000;
    forever begin
      @(negedge clk_i);
      take = wdata_ready_o & wdata_valid_i;
      @(posedge clk_i);
      #1;
      if (take[0] && wq0.size() > 0) void'(wq0.pop_front());
      if (take[1] && wq1.size() > 0) void'(wq1.pop_front());
      wdata_valid_i[0] = (wq0.size() > 0);
      wdata_valid_i[1] = (wq1.size() > 0);
      if (wq0.size() > 0) wdata_i[7:0] = wq0[0];
      if (wq1.size() > 0) wdata_i[15:8] = wq1[0];
    end
  end

  // Monitor: pops each scoreboard queue as the DUT presents the matching event.
  initial begin
    logic [10:0] ev;
    logic [10:0] prev_cmd;
    bit          prev_stall;
    bit          prev_rst;
    prev_stall = 1'b0;
    prev_rst = 1'b1;
    prev_cmd = '0;
    forever begin
      @(negedge clk_i);
      ev = (cmd_o == CMD_WRITE) ? {cmd_o, cmd_wdata_o} : {cmd_o, 8'h00};
      if (prev_stall && !prev_rst && !rst_i) begin
        check("cmd_held", cmd_valid_o, 1'b1);
        check("cmd_stable", ev, prev_cmd);
      end
      prev_stall = cmd_valid_o && !cmd_ready_i;
      prev_cmd = ev;
      prev_rst = rst_i;
      if (cmd_valid_o && cmd_ready_i && !rst_i) begin
        cmd_seen++;
        if (cmd_q.size() == 0) unexpected("cmd_unexpected", ev);
        else check("cmd", ev, cmd_q.pop_front());
      end
      if (|wdata_ready_o) wready_cycles++;
      if (|rdata_valid_o) begin
        rd_seen++;
        ev = {rdata_valid_o, rdata_last_o, rdata_o};
        if (rd_q.size() == 0) unexpected("rdata_unexpected", ev);
        else check("rdata", ev, rd_q.pop_front());
      end
      if (|req_ready_o) begin
        check("grant_while_busy", busy, 1'b0);
        busy = 1'b1;
        if (grant_q.size() == 0) unexpected("grant_unexpected", req_ready_o);
        else check("grant", req_ready_o, grant_q.pop_front());
      end
      if (|done_o) begin
        done_seen++;
        busy = 1'b0;
        if (done_q.size() == 0) unexpected("done_unexpected", {done_o, status_o});
        else check("done_status", {done_o, status_o}, done_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int w0;
    int r0;
    rst_i = 1'b1;
    req_valid_i = 2'b00;
    req_addr_i = '0;
    req_op_i = '0;
    req_len_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("reset");
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Write 0x22, two bytes.
    grant_q.push_back(2'b01);
    exp_cmd(CMD_START, 8'h00); exp_cmd(CMD_WRITE, 8'h44);
    exp_cmd(CMD_WRITE, 8'hA5); exp_cmd(CMD_WRITE, 8'h3C); exp_cmd(CMD_STOP, 8'h00);
    acks(5);
    done_q.push_back({2'b01, ST_OK});
    wq0.push_back(8'hA5); wq0.push_back(8'h3C);
    issue(0, 7'h22, 1'b0, 4'd2);
    wait_done(1);

    // Read 0x22, three bytes.
    grant_q.push_back(2'b10);
    exp_cmd(CMD_START, 8'h00); exp_cmd(CMD_WRITE, 8'h45);
    exp_cmd(CMD_READ_ACK, 8'h00); exp_cmd(CMD_READ_ACK, 8'h00);
    exp_cmd(CMD_READ_NAK, 8'h00); exp_cmd(CMD_STOP, 8'h00);
    acks(2); exp_rsp(1'b0, 1'b0, 8'h11); exp_rsp(1'b0, 1'b0, 8'h22);
    exp_rsp(1'b0, 1'b0, 8'h33); acks(1);
    rd_q.push_back({2'b10, 1'b0, 8'h11});
    rd_q.push_back({2'b10, 1'b0, 8'h22});
    rd_q.push_back({2'b10, 1'b1, 8'h33});
    done_q.push_back({2'b10, ST_OK});
    issue(1, 7'h22, 1'b1, 4'd3);
    wait_done(2);

    // Address NAK: STOP follows, no write-data handshake offered.
    grant_q.push_back(2'b01);
    exp_cmd(CMD_START, 8'h00); exp_cmd(CMD_WRITE, 8'hA0); exp_cmd(CMD_STOP, 8'h00);
    acks(1); exp_rsp(1'b1, 1'b0, 8'h00); acks(1);
    done_q.push_back({2'b01, ST_NAK});
    wq0.push_back(8'hEE); wq0.push_back(8'hDD);
    w0 = wready_cycles;
    issue(0, 7'h50, 1'b0, 4'd2);
    wait_done(3);
    check("nak_wdata_ready", wready_cycles - w0, 0);
    check("nak_wdata_left", wq0.size(), 2);
    wq0.delete();

    // Zero length: BAD_LEN, no bus commands.
    grant_q.push_back(2'b10);
    done_q.push_back({2'b10, ST_BAD_LEN});
    c0 = cmd_seen;
    issue(1, 7'h33, 1'b0, 4'd0);
    wait_done(4);
    check("badlen_cmds", cmd_seen - c0, 0);

    // Contention, two rounds: grants 0,1,0,1.
    for (int k = 0; k < 2; k++) begin
      grant_q.push_back(2'b01); grant_q.push_back(2'b10);
      exp_cmd(CMD_START, 8'h00); exp_cmd(CMD_WRITE, 8'h20);
      exp_cmd(CMD_WRITE, 8'h5A); exp_cmd(CMD_STOP, 8'h00);
      acks(4);
      exp_cmd(CMD_START, 8'h00); exp_cmd(CMD_WRITE, 8'h23);
      exp_cmd(CMD_READ_NAK, 8'h00); exp_cmd(CMD_STOP, 8'h00);
      acks(2); exp_rsp(1'b0, 1'b0, 8'h77); acks(1);
      rd_q.push_back({2'b10, 1'b1, 8'h77});
      done_q.push_back({2'b01, ST_OK}); done_q.push_back({2'b10, ST_OK});
      wq0.push_back(8'h5A);
      fork
        issue(0, 7'h10, 1'b0, 4'd1);
        issue(1, 7'h11, 1'b1, 4'd1);
      join
      wait_done(6 + 2 * k);
    end

    // Arbitration lost on the second data byte: no STOP.
    grant_q.push_back(2'b01);
    exp_cmd(CMD_START, 8'h00); exp_cmd(CMD_WRITE, 8'h60);
    exp_cmd(CMD_WRITE, 8'h01); exp_cmd(CMD_WRITE, 8'h02);
    acks(3); exp_rsp(1'b0, 1'b1, 8'h00);
    done_q.push_back({2'b01, ST_ARB_LOST});
    wq0.push_back(8'h01); wq0.push_back(8'h02);
    issue(0, 7'h30, 1'b0, 4'd2);
    wait_done(9);

    grant_q.push_back(2'b10);
    done_q.push_back({2'b10, ST_BAD_LEN});
    issue(1, 7'h01, 1'b0, 4'd0);
    wait_done(10);

    // Reset in the middle of a read, after the first byte.
    grant_q.push_back(2'b10);
    exp_cmd(CMD_START, 8'h00); exp_cmd(CMD_WRITE, 8'h45);
    exp_cmd(CMD_READ_ACK, 8'h00); exp_cmd(CMD_READ_ACK, 8'h00);
    acks(2); exp_rsp(1'b0, 1'b0, 8'h11); exp_rsp(1'b0, 1'b0, 8'h22);
    rd_q.push_back({2'b10, 1'b0, 8'h11});
    r0 = rd_seen;
    issue(1, 7'h22, 1'b1, 4'd3);
    for (int i = 0; i < 3000 && rd_seen == r0; i++) @(negedge clk_i);
    check("reset_test_first_byte", rd_seen - r0, 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_reset_outputs("midreset");
    rst_i = 1'b0;
    repeat (8) @(negedge clk_i);
    check("midreset_no_done", done_seen, 10);
    check("midreset_no_rdata", rd_seen - r0, 1);
    cmd_q.delete(); rsp_q.delete(); rd_q.delete();
    busy = 1'b0;

    // After reset priority is back at requester 0.
    grant_q.push_back(2'b01); grant_q.push_back(2'b10);
    done_q.push_back({2'b01, ST_BAD_LEN}); done_q.push_back({2'b10, ST_BAD_LEN});
    fork
      issue(0, 7'h05, 1'b0, 4'd0);
      issue(1, 7'h06, 1'b0, 4'd0);
    join
    wait_done(12);

    repeat (5) @(negedge clk_i);
    check("cmd_q_empty", cmd_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    check("grant_q_empty", grant_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_sequencer.md
I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

Interface
REQ-001 Parameter: I2C_ADDR_WIDTH, default 7, target address width.
REQ-002 Parameter: I2C_DATA_WIDTH, default 8, byte width.
REQ-003 Parameter: LEN_WIDTH, default 4, transfer-length width; maximum 15 bytes per transfer.
REQ-004 Port list:
- clk_i  in  1  system clock, single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  2  per-requester transfer request.
- req_ready_o  out  2  one-hot request accept.
- req_addr_i  in  2x7  per-requester target address.
- req_op_i  in  2  per-requester op: 1 = read, 0 = write (i2c_op_t).
- req_len_i  in  2x4  per-requester byte count.
- wdata_i  in  2x8  per-requester write byte.
- wdata_valid_i  in  2  write byte valid.
- wdata_ready_o  out  2  write byte accept.
- rdata_o  out  8  read byte to the owner.
- rdata_valid_o  out  2  one-hot read byte strobe.
- rdata_last_o  out  1  final read byte.
- done_o  out  2  one-hot transfer-complete pulse.
- status_o  out  2  i2c_status_t: OK, NAK, ARB_LOST, BAD_LEN.
- cmd_valid_o  out  1  byte-engine command valid.
- cmd_ready_i  in  1  byte-engine command accept.
- cmd_o  out  3  i2c_cmd_t: START, STOP, WRITE, READ_ACK, READ_NAK.
- cmd_wdata_o  out  8  byte for WRITE.
- rsp_valid_i  in  1  engine command completion.
- rsp_nak_i  in  1  slave NAK on WRITE.
- rsp_arb_lost_i  in  1  arbitration lost.
- rsp_rdata_i  in  8  read byte.

Function
REQ-005 FSM states and transitions:
- IDLE -> START -> ADDR.
- ADDR -> WDATA (write) or RDATA (read).
- WDATA/RDATA -> STOP -> DONE -> IDLE.
REQ-006 Exactly one command is outstanding at a time. The next cmd_valid_o is not raised until rsp_valid_i for the previous command.
REQ-007 cmd_valid_o is held with cmd_o and cmd_wdata_o stable until cmd_valid_o and cmd_ready_i are both high.
REQ-008 IDLE arbitration:
- Round-robin between requesters with req_valid_i high.
- Requester 0 has priority after reset.
- Priority toggles after each grant.
- req_ready_o pulses one cycle for the winner.
- The winner's addr, op and len are latched.
REQ-009 START is issued with cmd_valid_o high in the cycle after the grant (grant-to-command latency: 1 cycle).
REQ-010 ADDR issues WRITE with cmd_wdata_o = {addr, op}, op in the LSB.
REQ-011 WDATA, per byte:
- wdata_ready_o for the owner asserts only in a cycle when WRITE is about to be issued.
- The byte is captured on wdata_valid_i and wdata_ready_o both high.
- WRITE is then issued.
- Repeats until len bytes have completed.
REQ-012 RDATA issues READ_ACK for bytes 1..len-1 and READ_NAK for byte len.
REQ-013 Each rsp_valid_i during RDATA:
- rdata_o takes rsp_rdata_i.
- The owner's rdata_valid_o bit pulses one cycle.
- rdata_last_o pulses on byte len.
REQ-014 rsp_nak_i during ADDR or WDATA aborts the transfer: go to STOP, status NAK, no further data handshakes.
REQ-015 rsp_arb_lost_i on any response:
- Go directly to DONE without STOP.
- Status ARB_LOST.
REQ-016 len = 0 at grant:
- No bus command is issued.
- DONE is reached in the next cycle with status BAD_LEN.
REQ-017 DONE:
- Pulses the owner's done_o for exactly one cycle.
- status_o is valid in that cycle and holds until the next DONE.
- Then returns to IDLE.
REQ-018 A new request is granted no earlier than the cycle after DONE.
- Both requesters valid in the same cycle: resolved per REQ-008.
REQ-019 Requests raised mid-transfer wait; req_ready_o stays low outside IDLE.
REQ-020 The byte counter is LEN_WIDTH bits, counts completed bytes, and never wraps (max 15 completions).

Reset
REQ-021 On rst_i high at a clock edge:
- State goes to IDLE.
- All valid, ready, done and last outputs go to 0.
- status_o goes to OK; rdata_o, cmd_o and cmd_wdata_o go to 0.
- Round-robin pointer goes to requester 0.
- Byte counter clears.
REQ-022 Reset mid-transfer abandons it immediately:
- No STOP is issued.
- No done_o pulse.
- Any in-flight rsp_valid_i is ignored.

Structure
REQ-023 i2c_op_t, i2c_cmd_t, i2c_status_t and the width constants live in the shared globals package.
REQ-024 The round-robin arbiter is one sub-module, i2c_rr_arbiter.
- Inputs: request vector, advance strobe.
- Outputs: one-hot grant, pointer state.

Verification
REQ-025 Write, req0: addr 0x22, len 2, bytes 0xA5 then 0x3C, engine ACKs all.
- Commands: START, WRITE 0x44, WRITE 0xA5, WRITE 0x3C, STOP.
- done_o = 01, status OK.
REQ-026 Read, req1: addr 0x22, len 3, engine returns 0x11, 0x22, 0x33.
- Commands: START, WRITE 0x45, READ_ACK, READ_ACK, READ_NAK, STOP.
- rdata_last_o asserts with 0x33.
REQ-027 Address NAK: rsp_nak_i on the address byte.
- STOP follows and status is NAK.
- wdata_ready_o never asserts.
REQ-028 Contention: both requesters valid in the same cycle, repeatedly.
- Grants go 0, 1, 0, 1; no grant precedes the prior done_o.
REQ-029 Abnormal terminations:
- rsp_arb_lost_i on the second data byte gives ARB_LOST with no STOP.
- len = 0 gives BAD_LEN with zero commands issued.
REQ-030 rst_i asserted mid-RDATA: all outputs reach reset values next cycle, and a new request is accepted normally afterwards.
